// File: rtl/instruction_fetch.sv
// Instruction fetch: preloadable imem, PC/next-PC select, IDLE/RUN/HALT control.
// Instr/Op are combinational from PC (zero wait states); PC and instr_count advance once per edge in RUN.
module instruction_fetch #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [31:0]                   load_data,
  input  logic                          start,
  input  logic                          Jump,
  input  logic                          BrEq,
  input  logic                          BrNeq,
  input  logic                          Zero,
  output logic [31:0]                   Instr,
  output logic [5:0]                    Op,
  output logic [31:0]                   PC,
  output logic [31:0]                   PCPlus4,
  output logic                          running,
  output logic                          halted,
  output logic [31:0]                   instr_count
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);
  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   imem [IMEM_DEPTH];
  logic [AW-1:0] fetch_idx;
  logic          mem_we;
  logic          take_branch;
  logic [31:0]   branch_off;
  logic [31:0]   pc_plus4;
  logic [31:0]   next_pc;

  // imem has no reset so a loaded program survives reset and can be re-run.
  assign mem_we = (state_q == IDLE) && load_en;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      imem[load_addr] <= load_data;
    end
  end

  assign fetch_idx   = pc_q[AW+1:2];
  assign Instr       = (state_q == RUN) ? imem[fetch_idx] : 32'h0000_0000;
  assign Op          = Instr[31:26];
  assign pc_plus4    = pc_q + 32'd4;
  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4;
  assign running     = (state_q == RUN);
  assign halted      = (state_q == HALT);
  assign instr_count = count_q;

  assign take_branch = (BrEq & Zero) | (BrNeq & ~Zero);
  assign branch_off  = {{14{Instr[15]}}, Instr[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (Jump) begin
      next_pc = {pc_plus4[31:28], Instr[25:0], 2'b00};
    end else if (take_branch) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // The halt word itself is neither counted nor allowed to move the PC.
        if (Instr == HALT_WORD) begin
          state_d = HALT;
        end else begin
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_INIT;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: table of jump/branch vectors plus halt, reset and load-lockout sequences.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic        start;
  logic        Jump;
  logic        BrEq;
  logic        BrNeq;
  logic        Zero;
  logic [31:0] Instr;
  logic [5:0]  Op;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        running;
  logic        halted;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .Jump        (Jump),
    .BrEq        (BrEq),
    .BrNeq       (BrNeq),
    .Zero        (Zero),
    .Instr       (Instr),
    .Op          (Op),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .running     (running),
    .halted      (halted),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] target;
    logic [31:0] instr;
    logic        jump;
    logic        breq;
    logic        brneq;
    logic        zero;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic load(input logic [5:0] addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    tick();
    load_en   = 1'b0;
  endtask

  initial begin
    logic [31:0] jword;
    logic [31:0] widx;
    logic [5:0]  op_exp;

    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; Jump = 1'b0; BrEq = 1'b0; BrNeq = 1'b0; Zero = 1'b0;

    //            target        instr         J     BEq   BNe   Z     exp_pc
    vecs[0] = '{32'h0000_000C, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010};
    vecs[1] = '{32'h0000_0010, 32'h1000_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0010};
    vecs[2] = '{32'h0000_0010, 32'h1000_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0014};
    vecs[3] = '{32'h0000_0020, 32'h1400_0002, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_002C};
    vecs[4] = '{32'h0000_0020, 32'h1400_0002, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0024};
    vecs[5] = '{32'h0000_0030, 32'h0800_0005, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0014};
    vecs[6] = '{32'h0000_0018, 32'h1400_0010, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_005C};
    vecs[7] = '{32'h0000_0104, 32'h1000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0108};
    vecs[8] = '{32'h0000_0010, 32'h1000_8000, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFE_0014};
    vecs[9] = '{32'h0000_0030, 32'h1000_0007, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0034};

    #12;
    reset = 1'b0;
    chk("rst_pc", PC, 32'h0);
    chk("rst_count", instr_count, 32'h0);
    chk("rst_running", {31'b0, running}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_instr", Instr, 32'h0);

    for (int i = 0; i < 64; i++) load(i[5:0], 32'h0000_0000);

    // IDLE shows no instruction even when memory holds something at PC.
    load(6'd0, 32'h1234_5678);
    chk("idle_instr", Instr, 32'h0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      jword = 32'h0800_0000 | (vecs[i].target >> 2);
      widx  = (vecs[i].target >> 2) & 32'h3F;
      load(6'd0, jword);
      load(widx[5:0], vecs[i].instr);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk($sformatf("v%0d_run", i), {31'b0, running}, 32'h1);
      chk($sformatf("v%0d_jword", i), Instr, jword);
      Jump = 1'b1;
      tick();
      Jump = 1'b0;
      chk($sformatf("v%0d_pc_tgt", i), PC, vecs[i].target);
      chk($sformatf("v%0d_cnt1", i), instr_count, 32'd1);
      Jump  = vecs[i].jump;
      BrEq  = vecs[i].breq;
      BrNeq = vecs[i].brneq;
      Zero  = vecs[i].zero;
      #1;
      op_exp = vecs[i].instr[31:26];
      chk($sformatf("v%0d_instr", i), Instr, vecs[i].instr);
      chk($sformatf("v%0d_op", i), {26'b0, Op}, {26'b0, op_exp});
      chk($sformatf("v%0d_pcp4", i), PCPlus4, vecs[i].target + 32'd4);
      tick();
      chk($sformatf("v%0d_pc_next", i), PC, vecs[i].exp_pc);
      chk($sformatf("v%0d_cnt2", i), instr_count, 32'd2);
      Jump = 1'b0; BrEq = 1'b0; BrNeq = 1'b0; Zero = 1'b0;
    end

    // Halt sequence; the halt word is written on the same edge as start.
    do_reset();
    load(6'd0, 32'h0000_0001);
    load(6'd1, 32'h0000_0002);
    load_en = 1'b1; load_addr = 6'd2; load_data = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    chk("h_running", {31'b0, running}, 32'h1);
    chk("h_instr0", Instr, 32'h0000_0001);
    tick();
    chk("h_pc4", PC, 32'h4);
    tick();
    chk("h_pc8", PC, 32'h8);
    chk("h_haltword", Instr, 32'hFFFF_FFFF);
    tick();
    chk("h_halted", {31'b0, halted}, 32'h1);
    chk("h_notrun", {31'b0, running}, 32'h0);
    chk("h_pc_hold", PC, 32'h8);
    chk("h_count", instr_count, 32'd2);
    chk("h_instr_zero", Instr, 32'h0);
    start = 1'b1; load_en = 1'b1; load_addr = 6'd0; load_data = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; load_en = 1'b0;
    chk("h_stay_halted", {31'b0, halted}, 32'h1);
    chk("h_pc_after_pulse", PC, 32'h8);
    chk("h_cnt_after_pulse", instr_count, 32'd2);

    // Reset clears HALT; imem survives, and loads during RUN are ignored.
    do_reset();
    chk("r_halted_clr", {31'b0, halted}, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r_instr_kept", Instr, 32'h0000_0001);
    load_en = 1'b1; load_addr = 6'd0; load_data = 32'hAAAA_5555;
    tick();
    load_en = 1'b0;
    chk("r_pc4", PC, 32'h4);
    chk("r_cnt1", instr_count, 32'd1);

    // Asynchronous reset mid-RUN, observed before the next edge.
    reset = 1'b1;
    #1;
    chk("a_pc", PC, 32'h0);
    chk("a_running", {31'b0, running}, 32'h0);
    chk("a_count", instr_count, 32'h0);
    chk("a_instr", Instr, 32'h0);
    #1;
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_restart_instr", Instr, 32'h0000_0001);
    chk("a_restart_op", {26'b0, Op}, 32'h0);
    tick();
    tick();
    tick();
    chk("a_rehalt", {31'b0, halted}, 32'h1);
    chk("a_rehalt_cnt", instr_count, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter IMEM_DEPTH, default 64, instruction memory depth in 32-bit words; power of two.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value after reset; bits [1:0] forced to 0.
REQ-003 Parameter HALT_WORD, default 32'hFFFF_FFFF, instruction encoding that stops fetch.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 load_en  input  1  write enable for program preload, honoured only in IDLE.
REQ-007 load_addr  input  log2(IMEM_DEPTH)  word index for preload write.
REQ-008 load_data  input  32  instruction word for preload write.
REQ-009 start  input  1  begin execution from current PC, honoured only in IDLE.
REQ-010 Jump  input  1  jump select from main control.
REQ-011 BrEq  input  1  branch-if-equal select from main control.
REQ-012 BrNeq  input  1  branch-if-not-equal select from main control.
REQ-013 Zero  input  1  ALU zero flag for the current instruction.
REQ-014 Instr  output  32  current instruction word.
REQ-015 Op  output  6  Instr[31:26], opcode to main control.
REQ-016 PC  output  32  current program counter.
REQ-017 PCPlus4  output  32  PC + 4, modulo 2^32.
REQ-018 running  output  1  high while state is RUN.
REQ-019 halted  output  1  high while state is HALT.
REQ-020 instr_count  output  32  number of instructions retired since reset.

Function
REQ-021 FSM states SHALL be IDLE, RUN, HALT.
REQ-022 IDLE -> RUN on rising edge with start=1; RUN -> HALT on rising edge with Instr==HALT_WORD; HALT exits only via reset.
REQ-023 In IDLE, load_en=1 SHALL write load_data to imem[load_addr] on the rising edge; load_en=1 together with start=1 SHALL perform the write and the transition on the same edge.
REQ-024 load_en and start SHALL be ignored in RUN and HALT.
REQ-025 Instr SHALL be a combinational read of imem[PC[log2(IMEM_DEPTH)+1:2]] in RUN, and 32'h0000_0000 in IDLE and HALT.
REQ-026 The imem index SHALL wrap modulo IMEM_DEPTH; PC arithmetic SHALL wrap modulo 2^32.
REQ-027 In RUN, when Instr!=HALT_WORD, PC SHALL update every rising edge to next_pc, and instr_count SHALL increment by 1.
REQ-028 next_pc = {PCPlus4[31:28], Instr[25:0], 2'b00} when Jump=1.
REQ-029 Otherwise next_pc = PCPlus4 + (sign-extended Instr[15:0] << 2) when (BrEq & Zero) | (BrNeq & ~Zero).
REQ-030 Otherwise next_pc = PCPlus4.
REQ-031 Jump SHALL take priority over BrEq/BrNeq when both are asserted.
REQ-032 On the HALT_WORD edge, PC and instr_count SHALL hold; the halt instruction is not counted.
REQ-033 PC and instr_count SHALL hold in IDLE and HALT.
REQ-034 PC[1:0] SHALL always read 2'b00.
REQ-035 Latency: the next instruction's Instr/Op SHALL be valid combinationally after the PC-updating edge, with zero wait states.

Reset
REQ-036 Reset SHALL asynchronously set state=IDLE, PC=RESET_PC, instr_count=0, running=0, halted=0, and Instr=0.
REQ-037 Reset asserted mid-RUN SHALL take effect immediately, without waiting for a clock edge.
REQ-038 Instruction memory contents SHALL be preserved across reset; a new start re-executes the loaded program.

Verification
REQ-039 Preload imem[0]=32'h0800_0003, start; with Jump=1 -> PC 0x0 then 0x0C one edge later, instr_count=1.
REQ-040 Preload imem[4]=32'h1000_FFFF at PC 0x10, BrEq=1: Zero=1 -> PC stays 0x10; Zero=0 -> PC becomes 0x14.
REQ-041 imem[8]=32'h1400_0002 at PC 0x20, BrNeq=1, Zero=0 -> PC 0x2C; Zero=1 -> PC 0x24.
REQ-042 imem[0],imem[1] are non-halt words and imem[2]=HALT_WORD; run -> PC holds 0x08, halted=1, running=0, instr_count=2, Instr=0; start and load_en pulses then have no effect.
REQ-043 Assert reset between edges mid-RUN -> PC=0, running=0, instr_count=0 before the next edge; restart -> Instr equals the preloaded imem[0].
REQ-044 load_en=1 with load_addr=0 during RUN -> imem[0] unchanged, verified after reset and restart.
